west_stream_collector: RTL and testbench
========================================

# west_stream_collector

Downstream collector for the west output stream of an array add/mul block. Captures valid 128-bit beats, or in pack mode extracts the [127:96] scalar from each beat and packs four scalars per beat. Frames the stream into groups of DATA_NUM input words and buffers the result in a FIFO. Drains the FIFO to the next consumer over a valid/ready handshake with a per-frame last marker.

## Interface
Parameters:
- DATA_NUM, 192: input words per frame; range 1..1023.
- DEPTH, 256: FIFO entries; must be a power of two.
- AW, 8: log2(DEPTH).

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; asynchronous, active-low.
- clear  in  1  synchronous clear pulse.
- stage_start  in  1  input gate; beats are captured only while this is high.
- pack_en  in  1  0 = pass each beat whole; 1 = pack four scalars per beat.
- in_tvalid  in  1  input beat valid (no backpressure available).
- in_tdata  in  128  input beat.
- m_tvalid  out  1  output beat valid.
- m_tready  in  1  downstream ready.
- m_tdata  out  128  output beat.
- m_tlast  out  1  marks the last beat of a frame.
- frame_done  out  1  one-cycle pulse when the frame's last beat is accepted.
- overflow  out  1  sticky flag: a beat was dropped.
- fifo_level  out  AW+1  current FIFO occupancy.

## Operation
- Accepted input word: in_tvalid && stage_start on a clock edge. in_tvalid while stage_start=0 is ignored and not counted.
- in_cnt (10 bit) counts accepted words 0..DATA_NUM-1, then wraps to 0.
  - Dropped words are still counted, so frame alignment is preserved.
- Unpacked mode (pack_en=0): each accepted word pushes {in_tdata, last}. last = (in_cnt==DATA_NUM-1).
- Packed mode (pack_en=1):
  - Word k of a group (k = 0..3, pk_cnt) is placed at bits [127-32k -: 32] of the pack register.
  - A push happens on the 4th word, or on the frame-end word.
  - On a frame-end push, unfilled lanes are zero and last=1; pk_cnt resets.
  - pack_en must only change while the pipeline is idle (in_cnt==0 && pk_cnt==0). A change at any other time is undefined.
- FIFO: DEPTH x 129 bits (data + last). Pointers are AW+1 bits; full/empty come from MSB comparison.
- Push while full with no pop in the same cycle: the beat is dropped and overflow is set. Framing continues.
- Push while full with a pop in the same cycle: the push is accepted and the level is unchanged.
- Pop: m_tvalid && m_tready.
- frame_done = registered (pop && m_tlast).
- clear: synchronous. Empties the FIFO and zeroes in_cnt, pk_cnt, the pack register and overflow. Overrides any push or pop in the same cycle.
- Async reset has the same effect as clear.

## Timing
- Reset values: m_tvalid=0, m_tdata=0, m_tlast=0, frame_done=0, overflow=0, fifo_level=0.
- Latency from the pushing input edge to m_tvalid=1 is 1 cycle when the FIFO was empty (registered head).
- Handshake:
  - m_tdata and m_tlast hold stable while m_tvalid && !m_tready.
  - m_tvalid never drops without a pop.
  - m_tdata and m_tlast are 0 while m_tvalid=0.
- Throughput:
  - One push per cycle in unpacked mode; one push per 4 cycles in packed mode.
  - One pop per cycle sustained when m_tready=1.
- fifo_level updates on the edge after a push or pop. It reads DEPTH when full.
- frame_done asserts the cycle after the last-beat pop and lasts exactly one cycle.
- overflow is set the cycle after the dropped push and stays set until clear or reset.

## Test plan
- Unpacked frame: DATA_NUM=192, pack_en=0, 192 consecutive beats with word i = {4{i}}, m_tready=1.
  - Expect 192 output beats in order, each matching its input.
  - m_tlast only on beat 191; frame_done once, 1 cycle after beat 191 is accepted; first m_tvalid 1 cycle after the first input.
- Packed with partial tail: DATA_NUM=6, pack_en=1, words 1..6.
  - Expect beat 0 = {1,2,3,4}, last=0.
  - Expect beat 1 = {5,6,0,0}, last=1.
- Backpressure and overflow: DEPTH=4, m_tready=0, 6 beats pushed.
  - fifo_level reaches 4; beats 5 and 6 dropped; overflow=1.
  - With m_tready=1, exactly beats 1..4 drain and m_tdata is stable while stalled.
  - Next frame's tlast still lands on input word DATA_NUM-1.
- Full with simultaneous push/pop: FIFO full, m_tready=1, in_tvalid=1 for 10 cycles.
  - Expect no overflow, fifo_level constant at DEPTH, data in order.
- Gating, clear and reset:
  - in_tvalid=1 with stage_start=0: no push, in_cnt unchanged.
  - clear mid-frame after 3 packed words: FIFO empty and m_tvalid=0 the next cycle; the next frame starts at lane 0 with in_cnt=0.
  - rst_n low mid-drain: all outputs go to their reset values immediately.

Source files
------------

// File: rtl/west_stream_collector_if.sv
// Stream bundle for west_stream_collector.
// Carries the input beat stream (no backpressure) and the output
// valid/ready stream with its frame-last marker.
//   slave  : collector side (consumes in_*, drives m_* except m_tready)
//   master : environment side (drives in_* and m_tready)
interface west_stream_collector_if #(parameter int W = 128);
  logic         in_tvalid;
  logic [W-1:0] in_tdata;
  logic         m_tvalid;
  logic         m_tready;
  logic [W-1:0] m_tdata;
  logic         m_tlast;

  modport slave  (input  in_tvalid, in_tdata, m_tready,
                  output m_tvalid, m_tdata, m_tlast);
  modport master (output in_tvalid, in_tdata, m_tready,
                  input  m_tvalid, m_tdata, m_tlast);
endinterface

// File: rtl/west_stream_collector.sv
// west_stream_collector
// Collects the west output stream of the array add/mul block, frames it
// into groups of DATA_NUM input words, optionally packs the [127:96]
// scalar of four words into one beat, and buffers beats in a FIFO that
// drains over valid/ready with a per-frame last marker.
// Ports:
//   clk, rst_n     clock, async active-low reset
//   clear          sync clear (FIFO, counters, pack reg, overflow)
//   stage_start    input gate; words are accepted only while high
//   pack_en        0 = whole beats, 1 = pack four scalars per beat
//   bus            in_tvalid/in_tdata in, m_tvalid/m_tready/m_tdata/m_tlast out
//   frame_done     one-cycle pulse after the last beat of a frame pops
//   overflow       sticky: a beat was dropped on a full FIFO
//   fifo_level     current occupancy, 0..DEPTH
module west_stream_collector #(
  parameter int DATA_NUM = 192,
  parameter int DEPTH    = 256,
  parameter int AW       = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          clear,
  input  logic                          stage_start,
  input  logic                          pack_en,
  west_stream_collector_if.slave        bus,
  output logic                          frame_done,
  output logic                          overflow,
  output logic [AW:0]                   fifo_level
);

  // FIFO entry layout: {last, data}
  logic [9:0]   r_in_cnt;
  logic [1:0]   r_pk_cnt;
  logic [127:0] r_pack;
  logic [AW:0]  r_wr_ptr, r_rd_ptr;
  logic [128:0] r_mem [DEPTH];
  logic         r_m_tvalid, r_m_tlast, r_frame_done, r_overflow;
  logic [127:0] r_m_tdata;

  logic         w_acc, w_frame_end, w_push, w_full, w_pop, w_wr_en;
  logic [127:0] w_pack_next;
  logic [128:0] w_push_entry, w_head;
  logic [AW:0]  w_wr_ptr_n, w_rd_ptr_n;

  assign w_acc       = bus.in_tvalid && stage_start;
  assign w_frame_end = (r_in_cnt == 10'(DATA_NUM - 1));

  // Scalar k of a group lands in lane k counted from the MSB end.
  always_comb begin
    w_pack_next = r_pack;
    case (r_pk_cnt)
      2'd0: w_pack_next[127:96] = bus.in_tdata[127:96];
      2'd1: w_pack_next[95:64]  = bus.in_tdata[127:96];
      2'd2: w_pack_next[63:32]  = bus.in_tdata[127:96];
      default: w_pack_next[31:0] = bus.in_tdata[127:96];
    endcase
  end

  always_comb begin
    w_push       = 1'b0;
    w_push_entry = '0;
    if (w_acc) begin
      if (pack_en) begin
        // Flush on a full group or on the frame end (unfilled lanes stay 0).
        w_push       = (r_pk_cnt == 2'd3) || w_frame_end;
        w_push_entry = {w_frame_end, w_pack_next};
      end else begin
        w_push       = 1'b1;
        w_push_entry = {w_frame_end, bus.in_tdata};
      end
    end
  end

  assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  // m_tvalid mirrors "FIFO not empty", so a pop always has an entry.
  assign w_pop   = r_m_tvalid && bus.m_tready;
  // A pop in the same cycle frees the slot, so a full FIFO still takes it.
  assign w_wr_en = w_push && (!w_full || w_pop);

  assign w_wr_ptr_n = r_wr_ptr + (AW+1)'(w_wr_en);
  assign w_rd_ptr_n = r_rd_ptr + (AW+1)'(w_pop);

  // Next head register value. When the new head is the entry being
  // written this cycle, bypass the memory so an empty FIFO shows the
  // beat one cycle after it was pushed.
  always_comb begin
    w_head = '0;
    if (w_wr_ptr_n != w_rd_ptr_n) begin
      if (w_wr_en && (w_rd_ptr_n == r_wr_ptr))
        w_head = w_push_entry;
      else
        w_head = r_mem[w_rd_ptr_n[AW-1:0]];
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr_en && !clear)
      r_mem[r_wr_ptr[AW-1:0]] <= w_push_entry;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_in_cnt     <= '0;
      r_pk_cnt     <= '0;
      r_pack       <= '0;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_m_tvalid   <= 1'b0;
      r_m_tlast    <= 1'b0;
      r_m_tdata    <= '0;
      r_frame_done <= 1'b0;
      r_overflow   <= 1'b0;
    end else if (clear) begin
      r_in_cnt     <= '0;
      r_pk_cnt     <= '0;
      r_pack       <= '0;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_m_tvalid   <= 1'b0;
      r_m_tlast    <= 1'b0;
      r_m_tdata    <= '0;
      r_frame_done <= 1'b0;
      r_overflow   <= 1'b0;
    end else begin
      r_wr_ptr                <= w_wr_ptr_n;
      r_rd_ptr                <= w_rd_ptr_n;
      r_m_tvalid              <= (w_wr_ptr_n != w_rd_ptr_n);
      {r_m_tlast, r_m_tdata}  <= w_head;
      r_frame_done            <= w_pop && r_m_tlast;
      if (w_push && w_full && !w_pop)
        r_overflow <= 1'b1;
      // Dropped words still advance the frame counter to keep alignment.
      if (w_acc)
        r_in_cnt <= w_frame_end ? 10'd0 : r_in_cnt + 10'd1;
      if (w_acc && pack_en) begin
        if (w_push) begin
          r_pk_cnt <= 2'd0;
          r_pack   <= '0;
        end else begin
          r_pk_cnt <= r_pk_cnt + 2'd1;
          r_pack   <= w_pack_next;
        end
      end
    end
  end

  assign bus.m_tvalid = r_m_tvalid;
  assign bus.m_tdata  = r_m_tdata;
  assign bus.m_tlast  = r_m_tlast;
  assign frame_done   = r_frame_done;
  assign overflow     = r_overflow;
  assign fifo_level   = r_wr_ptr - r_rd_ptr;

endmodule

// File: tb/tb_west_stream_collector.sv
// Bench for west_stream_collector: instance A (DATA_NUM=192, DEPTH=256)
// and instance B (DATA_NUM=6, DEPTH=4) share one stimulus; `sel` picks
// which instance the scoreboard and checks look at.
module tb_west_stream_collector;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic         clear = 1'b0, stage_start = 1'b0, pack_en = 1'b0;
  logic         in_tvalid = 1'b0, m_tready = 1'b0;
  logic [127:0] in_tdata = '0;

  west_stream_collector_if ifa ();
  west_stream_collector_if ifb ();
  assign ifa.in_tvalid = in_tvalid;
  assign ifa.in_tdata  = in_tdata;
  assign ifa.m_tready  = m_tready;
  assign ifb.in_tvalid = in_tvalid;
  assign ifb.in_tdata  = in_tdata;
  assign ifb.m_tready  = m_tready;

  logic       fda, ova, fdb, ovb;
  logic [8:0] lvla;
  logic [2:0] lvlb;

  west_stream_collector #(.DATA_NUM(192), .DEPTH(256), .AW(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .clear(clear), .stage_start(stage_start),
    .pack_en(pack_en), .bus(ifa.slave), .frame_done(fda), .overflow(ova),
    .fifo_level(lvla));

  west_stream_collector #(.DATA_NUM(6), .DEPTH(4), .AW(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .clear(clear), .stage_start(stage_start),
    .pack_en(pack_en), .bus(ifb.slave), .frame_done(fdb), .overflow(ovb),
    .fifo_level(lvlb));

  logic         sel = 1'b0;
  logic         sv, sl, sfd, sov;
  logic [127:0] sd;
  logic [8:0]   slvl;
  assign sv   = sel ? ifb.m_tvalid : ifa.m_tvalid;
  assign sl   = sel ? ifb.m_tlast  : ifa.m_tlast;
  assign sd   = sel ? ifb.m_tdata  : ifa.m_tdata;
  assign sfd  = sel ? fdb : fda;
  assign sov  = sel ? ovb : ova;
  assign slvl = sel ? {6'd0, lvlb} : lvla;

  int           total = 0, bad = 0, fd_cnt = 0;
  logic [128:0] exp_q [$];
  logic [128:0] mon_e;
  logic         mon_en = 1'b0, mon_prev = 1'b0;

  task automatic chk(input string tag, input logic [128:0] obs, input logic [128:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    chk(tag, 129'(obs), 129'(exp));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_clear();
    mon_en = 1'b0; in_tvalid = 1'b0; m_tready = 1'b0; clear = 1'b1;
    step();
    clear = 1'b0;
    exp_q.delete();
    mon_en = 1'b1;
  endtask

  task automatic drain(input int max);
    int n = 0;
    while ((exp_q.size() != 0 || sv) && n < max) begin
      step();
      n++;
    end
    chk("drain_left", 129'(exp_q.size()), 129'(0));
    step();
  endtask

  // Scoreboard: pops an expected beat for every handshake seen on the
  // selected instance; frame_done must follow a last-beat pop by one cycle.
  always @(negedge clk) begin
    if (!mon_en) begin
      mon_prev = 1'b0;
    end else begin
      chk1("frame_done", sfd, mon_prev);
      if (sfd) fd_cnt++;
      if (sv && m_tready) begin
        if (exp_q.size() == 0) chk("beat_extra", 129'(exp_q.size()), 129'(1));
        else begin
          mon_e = exp_q.pop_front();
          chk("beat", {sl, sd}, mon_e);
        end
        mon_prev = sl;
      end else begin
        mon_prev = 1'b0;
      end
      if (!sv) chk("idle_zero", {sl, sd}, 129'(0));
    end
  end

  initial begin
    step(); step();
    for (int s = 0; s < 2; s++) begin
      sel = 1'(s);
      #1;
      chk("rst_out", {sl, sd}, 129'(0));
      chk1("rst_vld", sv, 1'b0);
      chk1("rst_fd", sfd, 1'b0);
      chk1("rst_ovf", sov, 1'b0);
      chk("rst_lvl", 129'(slvl), 129'(0));
    end
    sel = 1'b0;
    rst_n = 1'b1;
    step();

    // unpacked 192-word frame on A
    mon_en = 1'b1; stage_start = 1'b1; pack_en = 1'b0; m_tready = 1'b1;
    chk1("a_pre_vld", sv, 1'b0);
    for (int i = 0; i < 192; i++) begin
      exp_q.push_back({(i == 191), {4{32'(i)}}});
      in_tvalid = 1'b1; in_tdata = {4{32'(i)}};
      step();
      if (i == 0) chk1("a_first_lat", sv, 1'b1);
    end
    in_tvalid = 1'b0;
    drain(3);
    chk("a_fd_cnt", 129'(fd_cnt), 129'(1));

    // packed with partial tail on B
    sel = 1'b1;
    do_clear();
    pack_en = 1'b1; m_tready = 1'b1; fd_cnt = 0;
    exp_q.push_back({1'b0, 32'd1, 32'd2, 32'd3, 32'd4});
    exp_q.push_back({1'b1, 32'd5, 32'd6, 64'd0});
    for (int w = 1; w <= 6; w++) begin
      in_tvalid = 1'b1; in_tdata = {32'(w), {3{32'hA5A5_5A5A}}};
      step();
      if (w == 3) chk1("b_no_early", sv, 1'b0);
      if (w == 4) chk1("b_lat", sv, 1'b1);
    end
    in_tvalid = 1'b0;
    drain(4);
    chk("b_fd_cnt", 129'(fd_cnt), 129'(1));

    // backpressure and overflow on B
    do_clear();
    pack_en = 1'b0; fd_cnt = 0;
    chk1("c_ovf_clr", sov, 1'b0);
    for (int i = 0; i < 6; i++) begin
      in_tvalid = 1'b1; in_tdata = {4{32'h10 + 32'(i)}};
      if (i < 4) exp_q.push_back({1'b0, {4{32'h10 + 32'(i)}}});
      step();
      if (i == 0) chk("c_head", {sl, sd}, {1'b0, {4{32'h10}}});
      if (i == 3) begin
        chk("c_lvl_full", 129'(slvl), 129'(4));
        chk1("c_ovf_pre", sov, 1'b0);
      end
      if (i == 4) chk1("c_ovf_set", sov, 1'b1);
    end
    in_tvalid = 1'b0;
    step(); step();
    chk("c_stall_hold", {sl, sd}, {1'b0, {4{32'h10}}});
    chk("c_lvl_hold", 129'(slvl), 129'(4));
    m_tready = 1'b1;
    drain(8);
    chk1("c_ovf_sticky", sov, 1'b1);
    chk("c_lvl_empty", 129'(slvl), 129'(0));
    for (int i = 0; i < 6; i++) begin
      exp_q.push_back({(i == 5), {4{32'h30 + 32'(i)}}});
      in_tvalid = 1'b1; in_tdata = {4{32'h30 + 32'(i)}};
      step();
    end
    in_tvalid = 1'b0;
    drain(4);
    chk("c_fd_cnt", 129'(fd_cnt), 129'(1));

    // full FIFO with simultaneous push and pop on B
    do_clear();
    fd_cnt = 0;
    for (int k = 0; k < 14; k++) begin
      exp_q.push_back({((k % 6) == 5), {4{32'h40 + 32'(k)}}});
      in_tvalid = 1'b1; in_tdata = {4{32'h40 + 32'(k)}};
      if (k == 4) m_tready = 1'b1;
      step();
      if (k >= 3) begin
        chk("d_lvl", 129'(slvl), 129'(4));
        chk1("d_ovf", sov, 1'b0);
      end
    end
    in_tvalid = 1'b0;
    drain(8);
    chk("d_fd_cnt", 129'(fd_cnt), 129'(2));

    // input gate on B
    do_clear();
    fd_cnt = 0; m_tready = 1'b1; stage_start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_tvalid = 1'b1; in_tdata = {4{32'hBAD0}};
      step();
      chk1("e_gate_vld", sv, 1'b0);
      chk("e_gate_lvl", 129'(slvl), 129'(0));
    end
    stage_start = 1'b1;
    for (int i = 0; i < 6; i++) begin
      exp_q.push_back({(i == 5), {4{32'h50 + 32'(i)}}});
      in_tvalid = 1'b1; in_tdata = {4{32'h50 + 32'(i)}};
      step();
    end
    in_tvalid = 1'b0;
    drain(4);
    chk("e_fd_cnt", 129'(fd_cnt), 129'(1));

    // clear mid-frame in packed mode on A
    sel = 1'b0;
    do_clear();
    pack_en = 1'b1;
    for (int w = 1; w <= 7; w++) begin
      in_tvalid = 1'b1; in_tdata = {32'(w), {3{32'h0F0F_F0F0}}};
      step();
    end
    chk1("f_pre_vld", sv, 1'b1);
    do_clear();
    chk1("f_clr_vld", sv, 1'b0);
    chk("f_clr_lvl", 129'(slvl), 129'(0));
    m_tready = 1'b1; fd_cnt = 0;
    for (int j = 0; j < 48; j++)
      exp_q.push_back({(j == 47), 32'(4*j+1), 32'(4*j+2), 32'(4*j+3), 32'(4*j+4)});
    for (int i = 0; i < 192; i++) begin
      in_tvalid = 1'b1; in_tdata = {32'(i + 1), {3{32'h0F0F_F0F0}}};
      step();
    end
    in_tvalid = 1'b0;
    drain(4);
    chk("f_fd_cnt", 129'(fd_cnt), 129'(1));

    // async reset mid-drain on B
    sel = 1'b1;
    do_clear();
    pack_en = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (i < 4) exp_q.push_back({1'b0, {4{32'h60 + 32'(i)}}});
      in_tvalid = 1'b1; in_tdata = {4{32'h60 + 32'(i)}};
      step();
    end
    in_tvalid = 1'b0; m_tready = 1'b1;
    step();
    chk1("g_ovf_before", sov, 1'b1);
    #2;
    mon_en = 1'b0; rst_n = 1'b0;
    #1;
    chk1("g_rst_vld", sv, 1'b0);
    chk("g_rst_out", {sl, sd}, 129'(0));
    chk1("g_rst_fd", sfd, 1'b0);
    chk1("g_rst_ovf", sov, 1'b0);
    chk("g_rst_lvl", 129'(slvl), 129'(0));
    step();
    rst_n = 1'b1;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
